// File: rtl/pipe_reg_stage_if.sv
// -----------------------------------------------------------------------------
// pipe_reg_stage_if
// Groups the producer/consumer handshake, flush and occupancy signals of
// pipe_reg_stage.
//   in_valid_i / in_data_i / in_ready_o    : upstream (producer) handshake
//   out_valid_o / out_data_o / out_ready_i : downstream (consumer) handshake
//   flush_i                                : synchronous discard of contents
//   count_o                                : number of occupied stages
// The master modport is the environment around the pipeline.
// The slave modport is the pipeline itself.
// -----------------------------------------------------------------------------
interface pipe_reg_stage_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_ready_i;
  logic             flush_i;
  logic [CW-1:0]    count_o;

  modport master (
    output in_valid_i, in_data_i, out_ready_i, flush_i,
    input  in_ready_o, out_valid_o, out_data_o, count_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i, flush_i,
    output in_ready_o, out_valid_o, out_data_o, count_o
  );
endinterface

// File: rtl/pipe_reg_stage.sv
// -----------------------------------------------------------------------------
// pipe_reg_stage
// A DEPTH-stage register pipeline for a WIDTH-bit payload.
// It provides valid/ready flow control and collapses bubbles.
// It also supports a synchronous flush and reports an occupancy count.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; overrides everything
//   bus   : pipe_reg_stage_if.slave (handshake, flush, count)
// Parameters: WIDTH, DEPTH (1..16), RST_VAL, RST_DATA (1 = data regs take
// RST_VAL on reset/flush, 0 = only valid bits clear).
// -----------------------------------------------------------------------------
module pipe_reg_stage #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               RST_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  pipe_reg_stage_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH:0]   rdy_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             emit_s;

  // rdy[i] is high when stage i is empty or its content moves on this edge.
  // An empty stage therefore accepts from upstream even under a downstream stall.
  function automatic logic [DEPTH:0] ready_chain(input logic [DEPTH-1:0] v,
                                                 input logic             ordy);
    logic [DEPTH:0] r;
    r[DEPTH] = ordy;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r[i] = ~v[i] | r[i+1];
    end
    return r;
  endfunction

  // Handshake decode: the ready chain and the accept/emit events.
  always_comb begin
    rdy_s      = ready_chain(valid_q, bus.out_ready_i);
    in_ready_s = rdy_s[0] & ~bus.flush_i & ~reset;
    accept_s   = bus.in_valid_i & in_ready_s;
    emit_s     = valid_q[DEPTH-1] & bus.out_ready_i;
  end

  // Next state of the stages and of the occupancy counter.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (bus.flush_i) begin
      valid_d = '0;
      count_d = '0;
      if (RST_DATA) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_d[i] = RST_VAL;
        end
      end else begin
        data_d = data_q;
      end
    end else begin
      // Stage 0 takes the producer beat.
      // Its data register only loads when the beat is valid.
      if (rdy_s[0]) begin
        valid_d[0] = bus.in_valid_i;
        if (bus.in_valid_i) begin
          data_d[0] = bus.in_data_i;
        end else begin
          data_d[0] = data_q[0];
        end
      end else begin
        valid_d[0] = valid_q[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy_s[i]) begin
          valid_d[i] = valid_q[i-1];
          if (valid_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end else begin
            data_d[i] = data_q[i];
          end
        end else begin
          valid_d[i] = valid_q[i];
        end
      end
      // Accept and emit in the same cycle cancel out.
      count_d = count_q + CW'(accept_s) - CW'(emit_s);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (RST_DATA) begin
          data_q[i] <= RST_VAL;
        end else begin
          data_q[i] <= data_q[i];
        end
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = valid_q[DEPTH-1];
  assign bus.out_data_o  = data_q[DEPTH-1];
  assign bus.count_o     = count_q;

  pipe_reg_stage_chk #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.flush_i),
    .valid     (valid_q),
    .count     (count_q),
    .out_valid (valid_q[DEPTH-1]),
    .out_ready (bus.out_ready_i),
    .out_data  (data_q[DEPTH-1])
  );
endmodule

// -----------------------------------------------------------------------------
// pipe_reg_stage_chk
// Checks the pipeline invariants in simulation only.
//   count equals the number of occupied stages.
//   The output payload holds while it is stalled.
// -----------------------------------------------------------------------------
module pipe_reg_stage_chk #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input logic                         clk,
  input logic                         reset,
  input logic                         flush,
  input logic [DEPTH-1:0]             valid,
  input logic [$clog2(DEPTH+1)-1:0]   count,
  input logic                         out_valid,
  input logic                         out_ready,
  input logic [WIDTH-1:0]             out_data
);
  a_count_popcount: assert property (@(posedge clk) disable iff (reset)
    (int'(count) == $countones(valid)))
    else $error("pipe_reg_stage: count does not match occupied stages");

  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && !flush) |=> $stable(out_data))
    else $error("pipe_reg_stage: out_data changed under stall");
endmodule

// File: tb/tb_pipe_reg_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_stage
// Directed and random stimulus for pipe_reg_stage (WIDTH=8, DEPTH=3).
// The reference model keeps every beat as a (payload, position) pair.
// Each clock, the oldest beat moves forward or leaves the pipeline.
// A younger beat may advance up to one slot behind the beat ahead of it.
// -----------------------------------------------------------------------------
module tb_pipe_reg_stage;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic clk;
  logic reset;

  pipe_reg_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_reg_stage #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RST_VAL  (8'h00),
    .RST_DATA (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  int peak = 0;

  logic [7:0] m_data[$];
  int         m_pos[$];
  logic [7:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge.
  // Also predict in_ready for the inputs currently applied.
  task automatic model_edge(input logic iv, input logic [7:0] id, input logic ordy,
                            input logic fl, input logic rst, output logic exp_rdy);
    int np[$];
    int n;
    logic [7:0] tmp;
    if (rst) begin
      m_data.delete();
      m_pos.delete();
      m_last  = 8'h00;
      exp_rdy = 1'b0;
    end else begin
      for (int k = 0; k < m_pos.size(); k++) begin
        if (k == 0) begin
          if (m_pos[0] == DEPTH - 1) n = ordy ? DEPTH : DEPTH - 1;
          else n = m_pos[0] + 1;
        end else begin
          n = m_pos[k] + 1;
          if (n > np[k-1] - 1) n = np[k-1] - 1;
        end
        np.push_back(n);
      end
      exp_rdy = !fl && !(np.size() > 0 && np[np.size()-1] == 0);
      if (np.size() > 0 && np[0] == DEPTH) begin
        n   = np.pop_front();
        tmp = m_data.pop_front();
        delivered++;
      end
      if (fl) begin
        m_data.delete();
        m_pos.delete();
        m_last = 8'h00;
      end else begin
        m_pos = np;
        if (m_pos.size() > 0 && m_pos[0] == DEPTH - 1) m_last = m_data[0];
        if (iv && exp_rdy) begin
          m_data.push_back(id);
          m_pos.push_back(0);
        end
      end
    end
  endtask

  // Run one clock: drive the inputs and check in_ready.
  // After the edge, check the registered outputs against the model.
  task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic fl, input logic rst);
    logic exp_rdy;
    logic exp_valid;
    bus.in_valid_i  = iv;
    bus.in_data_i   = id;
    bus.out_ready_i = ordy;
    bus.flush_i     = fl;
    reset           = rst;
    #1;
    model_edge(iv, id, ordy, fl, rst, exp_rdy);
    chk("in_ready", {31'd0, bus.in_ready_o}, {31'd0, exp_rdy});
    @(posedge clk);
    @(negedge clk);
    exp_valid = (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
    chk("out_valid", {31'd0, bus.out_valid_o}, {31'd0, exp_valid});
    if (exp_valid) chk("out_data", {24'd0, bus.out_data_o}, {24'd0, m_data[0]});
    chk("count", {30'd0, bus.count_o}, m_pos.size());
    if (int'(bus.count_o) > peak) peak = int'(bus.count_o);
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 8'h00;
    bus.out_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
    reset           = 1'b1;
    m_last          = 8'h00;
    @(negedge clk);

    // Reset held for two cycles with a valid beat presented.
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    chk("reset_data", {24'd0, bus.out_data_o}, 32'h0000_0000);
    chk("reset_count", {30'd0, bus.count_o}, 32'd0);

    // Streaming at full throughput.
    peak = 0;
    cycle(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    chk("lat_not_yet", {31'd0, bus.out_valid_o}, 32'd0);
    cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    chk("lat_first", {24'd0, bus.out_data_o}, 32'h0000_0011);
    cycle(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("stream_peak", peak, 32'd3);

    // Stall fill: three beats fit and the fourth is refused.
    cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    chk("fill_count", {30'd0, bus.count_o}, 32'd3);
    cycle(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
    chk("stall_data", {24'd0, bus.out_data_o}, 32'h0000_00A1);
    cycle(1'b1, 8'hA4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Bubble collapse under a stalled output.
    cycle(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("bubble_count", {30'd0, bus.count_o}, 32'd2);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bubble_second", {24'd0, bus.out_data_o}, 32'h0000_0006);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush with a beat presented in the flush cycle.
    cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
    chk("flush_count", {30'd0, bus.count_o}, 32'd0);
    chk("flush_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("flush_data", {24'd0, bus.out_data_o}, 32'h0000_0000);

    // Full pipeline with simultaneous accept and emit.
    cycle(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0, 1'b0);
      chk("full_count", {30'd0, bus.count_o}, 32'd3);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Random valid/ready with occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) == 0), 1'b0);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drained_count", {30'd0, bus.count_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_reg_stage.md
Name: pipe_reg_stage

Overview:
- Parametrised multi-stage register pipeline.
- Moves a WIDTH-bit payload through DEPTH registered stages with valid/ready flow control, bubble collapsing, synchronous flush and an occupancy count.
- Next generation of the single-bit flop block: it generalises width and depth and adds handshake, stall and flush behaviour.
- Placed between producer/consumer blocks for timing retiming without loss of throughput.

Parameters:
- WIDTH, 8: payload bits per stage.
- DEPTH, 3: number of register stages; legal range 1..16.
- RST_VAL, 0: value loaded into every data register on reset/flush when RST_DATA=1.
- RST_DATA, 1: 1 = data registers reset/flush to RST_VAL; 0 = only valid bits are cleared and data registers hold.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid_i  input  1  producer has payload.
- in_data_i  input  WIDTH  producer payload.
- in_ready_o  output  1  pipeline accepts payload this cycle.
- out_valid_o  output  1  last stage holds payload.
- out_data_o  output  WIDTH  last stage payload.
- out_ready_i  input  1  consumer accepts payload.
- flush_i  input  1  synchronous discard of all contents.
- count_o  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clk. Reset has priority over everything.
- Reset/flush values (also after any cycle with flush_i=1): all stage valid bits 0, so out_valid_o=0 and count_o=0. Data registers = RST_VAL when RST_DATA=1, otherwise unchanged.
- Stage ready chain: rdy[DEPTH]=out_ready_i; rdy[i] = !valid[i] | rdy[i+1] for i=DEPTH-1..0.
- Chain output: combinational, no registered skid. in_ready_o = rdy[0] & !flush_i & !reset.
- Stage update on each edge, no reset/flush:
  - Stage 0 loads in_data_i with valid=in_valid_i when rdy[0].
  - Stage i>0 loads stage i-1 (data and valid) when rdy[i].
  - Stages with rdy low hold.
  - Data registers load only when the incoming valid=1; the valid bit is always updated when rdy.
- Bubble collapsing: an empty stage accepts from upstream even when downstream is stalled.
- Latency: an accepted beat appears on out_valid_o exactly DEPTH cycles after acceptance when no stall occurs.
- Throughput: 1 beat/cycle when out_ready_i is held 1.
- Ordering: strictly FIFO; no beat is duplicated or dropped except by flush/reset.
- Outputs: out_valid_o=valid[DEPTH-1] and out_data_o=data[DEPTH-1]; both are registered outputs.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o holds stable.
- count_o: registered. It is +1 on an accept-only cycle, -1 on an emit-only cycle and unchanged when both or neither occur. It never exceeds DEPTH.
- Full condition: count_o=DEPTH and out_ready_i=0 gives in_ready_o=0.
- Full with out_ready_i=1: in_ready_o=1 and simultaneous accept+emit are legal.
- Flush mid-operation: a beat presented in the flush cycle is not accepted (in_ready_o=0). A beat emitted in the flush cycle (out_valid_o & out_ready_i) counts as delivered.
- in_valid_i: may assert/deassert freely; in_data_i is ignored when in_valid_i=0.
- DEPTH=1: degenerates to a single handshake register with rdy[0] = !valid[0] | out_ready_i.
- Assertions (sim only):
  - count_o equals the popcount of the valid bits.
  - out_data_o is stable under stall.

Test Plan:
- Reset: hold reset 2 cycles with in_valid_i=1 -> out_valid_o=0, count_o=0, out_data_o=8'h00 (WIDTH=8, DEPTH=3, RST_VAL=0); in_ready_o=0 during reset.
- Streaming: send 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready_i=1 -> 0x11 emitted 3 cycles after acceptance, then one beat per cycle in order; count_o peaks at 3.
- Stall/fill: out_ready_i=0, send 0xA1..0xA4 -> first three accepted, count_o=3, in_ready_o=0 on the fourth; out_data_o=0xA1 stable. Raise out_ready_i -> 0xA1,0xA2,0xA3,0xA4 emitted in order.
- Bubble collapse: send 0x05, wait 2 idle cycles, send 0x06 with out_ready_i=0 -> both held in stages 2 and 1, count_o=2; release -> 0x05 then 0x06 on consecutive cycles.
- Flush: fill with 0x10,0x20,0x30, then assert flush_i for one cycle while presenting 0x40 -> next cycle count_o=0 and out_valid_o=0; 0x40 is not accepted and out_data_o=0x00.
- Full simultaneous: full pipeline with out_ready_i=1 and in_valid_i=1 every cycle -> count_o stays 3 and in_ready_o=1; random valid/ready for 2000 cycles against a scoreboard shows no loss, duplication or reordering.
